// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and types for the two-requester RAM port arbiter.
// Holds the RAM address width, requester count, FSM encoding and the round-robin pick.
package ram_port_arbiter_pkg;

  localparam int A_W   = 9;
  localparam int N_REQ = 2;

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Outstanding-read tag: which requester owns the data returning next cycle.
  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  // rr names the requester holding priority when both ask; a lone requester always wins.
  function automatic logic rr_pick(input logic [N_REQ-1:0] req, input logic rr);
    if (req == 2'b11) return rr;
    return req[1];
  endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters,
// with a one-cycle RAM clear sequence and read-response routing by tag.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = A_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [31:0]       wdata_0,
  output logic              gnt_0,
  output logic              rvalid_0,
  output logic [31:0]       rdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [31:0]       wdata_1,
  output logic              gnt_1,
  output logic              rvalid_1,
  output logic [31:0]       rdata_1,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic              ram_flush,
  output logic [31:0]       ram_din,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [31:0]       ram_dout,
  input  logic              ram_read_valid
);

  logic [0:0]       state_q, state_d;
  logic             rr_q, rr_d;
  tag_t             tag_q, tag_d;
  logic             flush_done_q, flush_done_d;

  logic [N_REQ-1:0] req_v;
  logic             arb_open;
  logic             flush_hit;
  logic             any_gnt;
  logic             winner;
  logic             win_we;
  logic             resp_ok;

  // NOTE: every signal written here gets a default before any branch, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    req_v        = {req_1, req_0};
    flush_hit    = !rst && (state_q == ST_ARB) && flush_req;
    arb_open     = !rst && (state_q == ST_ARB) && !flush_req;
    any_gnt      = arb_open && (|req_v);
    winner       = rr_pick(req_v, rr_q);
    win_we       = winner ? we_1 : we_0;

    gnt_0        = any_gnt && !winner;
    gnt_1        = any_gnt && winner;
    ram_ena      = any_gnt;
    ram_wea      = any_gnt && win_we;
    ram_addr     = winner ? addr_1 : addr_0;
    ram_din      = winner ? wdata_1 : wdata_0;
    ram_flush    = !rst && (state_q == ST_FLUSH);

    state_d      = state_q;
    case (state_q)
      ST_ARB:   if (flush_req) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_ARB;
      default:  state_d = ST_ARB;
    endcase

    rr_d         = any_gnt ? !winner : rr_q;
    // The tag only survives one cycle: it marks exactly the read granted now.
    tag_d.valid  = any_gnt && !win_we;
    tag_d.owner  = winner;
    flush_done_d = (state_q == ST_FLUSH);
  end

  // A response landing while a flush is being accepted or under reset is dropped.
  always_comb begin
    resp_ok  = ram_read_valid && tag_q.valid && !rst && !flush_hit;
    rvalid_0 = resp_ok && !tag_q.owner;
    rvalid_1 = resp_ok && tag_q.owner;
    rdata_0  = ram_dout;
    rdata_1  = ram_dout;
  end

  assign flush_done = flush_done_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values computed before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ARB;
      rr_q         <= 1'b0;
      tag_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      tag_q        <= tag_d;
      flush_done_q <= flush_done_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM and a read-response
// scoreboard checked by an independent monitor.
module tb_ram_port_arbiter;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_0, we_0, req_1, we_1, flush_req;
  logic [AW-1:0] addr_0, addr_1;
  logic [31:0]   wdata_0, wdata_1;
  logic          gnt_0, gnt_1, rvalid_0, rvalid_1, flush_done;
  logic [31:0]   rdata_0, rdata_1;
  logic          ram_ena, ram_wea, ram_flush, ram_read_valid;
  logic [31:0]   ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc_n  = 0;
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] mem [0:(1<<AW)-1];

  ram_port_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
    .flush_req(flush_req), .flush_done(flush_done),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_flush(ram_flush),
    .ram_din(ram_din), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .ram_read_valid(ram_read_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Single-port RAM: one-cycle read latency, dout reads all-ones after reset, flush zeroes contents.
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (rst) begin
      ram_dout       <= 32'hFFFF_FFFF;
      ram_read_valid <= 1'b0;
    end else begin
      ram_read_valid <= 1'b0;
      if (ram_flush) begin
        for (int i = 0; i < (1<<AW); i++) mem[i] <= 32'h0;
      end else if (ram_ena) begin
        if (ram_wea) mem[ram_addr] <= ram_din;
        else begin
          ram_dout       <= mem[ram_addr];
          ram_read_valid <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // One cycle of stimulus: eg = expected {gnt_1,gnt_0}, ef = ram_flush, ed = flush_done,
  // push = a read response with data rd is expected next cycle for the granted requester.
  task automatic cyc(input logic r, input logic [1:0] rq, input logic [1:0] we,
                     input logic [AW-1:0] a0, input logic [31:0] d0,
                     input logic [AW-1:0] a1, input logic [31:0] d1, input logic fl,
                     input logic [1:0] eg, input logic ef, input logic ed,
                     input logic push, input logic [31:0] rd);
    logic exp_we;
    @(negedge clk);
    rst = r; {req_1, req_0} = rq; {we_1, we_0} = we;
    addr_0 = a0; wdata_0 = d0; addr_1 = a1; wdata_1 = d1; flush_req = fl;
    #1;
    exp_we = eg[1] ? we[1] : (eg[0] & we[0]);
    check("gnt_0", 32'(gnt_0), 32'(eg[0]));
    check("gnt_1", 32'(gnt_1), 32'(eg[1]));
    check("ram_ena", 32'(ram_ena), 32'(|eg));
    check("ram_wea", 32'(ram_wea), 32'(exp_we));
    if (|eg) begin
      check("ram_addr", 32'(ram_addr), 32'(eg[1] ? a1 : a0));
      if (exp_we) check("ram_din", ram_din, eg[1] ? d1 : d0);
    end
    check("ram_flush", 32'(ram_flush), 32'(ef));
    check("flush_done", 32'(flush_done), 32'(ed));
    if (push) sb.push_back('{owner: eg[1], data: rd, cyc: cyc_n + 1});
  endtask

  task automatic idle(input logic ef, input logic ed);
    cyc(1'b0, 2'b00, 2'b00, '0, '0, '0, '0, 1'b0, 2'b00, ef, ed, 1'b0, '0);
  endtask

  // Monitor: every cycle, match any presented read response against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0 && sb[0].cyc < cyc_n) begin
        e = sb.pop_front();
        n_vec++;
        n_miss++;
        $display("FAIL missing_rvalid: got no response by cycle %0d, expected owner %0d data %h at cycle %0d",
                 cyc_n, e.owner, e.data, e.cyc);
      end
      if (rvalid_0 || rvalid_1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_rvalid: got rvalid_0=%b rvalid_1=%b, expected none (cycle %0d)",
                   rvalid_0, rvalid_1, cyc_n);
        end else begin
          e = sb.pop_front();
          check("rvalid_0", 32'(rvalid_0), 32'(!e.owner));
          check("rvalid_1", 32'(rvalid_1), 32'(e.owner));
          check("rdata", e.owner ? rdata_1 : rdata_0, e.data);
          check("read_latency", 32'(cyc_n), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, expected completion within 20000 cycles");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_0 = 0; we_0 = 0; req_1 = 0; we_1 = 0; flush_req = 0;
    addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
    repeat (2) @(posedge clk);

    // Reset: requests and flush ignored, RAM data reads all-ones.
    cyc(1, 2'b11, 2'b00, 8'd1, 0, 8'd2, 0, 1, 2'b00, 0, 0, 0, 0);
    check("rst_rdata_0", rdata_0, 32'hFFFF_FFFF);
    check("rst_rdata_1", rdata_1, 32'hFFFF_FFFF);

    // Lone requester 0: write then read back addr 5.
    cyc(0, 2'b01, 2'b01, 8'd5, 32'hA5A5_A5A5, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    cyc(0, 2'b01, 2'b00, 8'd5, 0, 0, 0, 0, 2'b01, 0, 0, 1, 32'hA5A5_A5A5);
    idle(0, 0);

    // Preload addr 10/11, then reset so the pointer favours requester 0.
    cyc(0, 2'b10, 2'b10, 0, 0, 8'd10, 32'h1111_0010, 0, 2'b10, 0, 0, 0, 0);
    cyc(0, 2'b01, 2'b01, 8'd11, 32'h2222_0011, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    cyc(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

    // Both read continuously: grants alternate 0,1,0,1.
    cyc(0, 2'b11, 2'b00, 8'd10, 0, 8'd11, 0, 0, 2'b01, 0, 0, 1, 32'h1111_0010);
    cyc(0, 2'b11, 2'b00, 8'd10, 0, 8'd11, 0, 0, 2'b10, 0, 0, 1, 32'h2222_0011);
    cyc(0, 2'b11, 2'b00, 8'd10, 0, 8'd11, 0, 0, 2'b01, 0, 0, 1, 32'h1111_0010);
    cyc(0, 2'b11, 2'b00, 8'd10, 0, 8'd11, 0, 0, 2'b10, 0, 0, 1, 32'h2222_0011);
    idle(0, 0);

    // Flush beats a read request; contents cleared; grant allowed alongside flush_done.
    cyc(0, 2'b01, 2'b01, 8'd3, 32'h0000_1234, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    cyc(0, 2'b10, 2'b00, 0, 0, 8'd3, 0, 1, 2'b00, 0, 0, 0, 0);
    cyc(0, 2'b01, 2'b00, 8'd3, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
    cyc(0, 2'b10, 2'b00, 0, 0, 8'd3, 0, 0, 2'b10, 0, 1, 1, 32'h0);
    idle(0, 0);

    // Read in flight when a flush is requested: its response is suppressed.
    cyc(0, 2'b01, 2'b00, 8'd3, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
    idle(1, 0);
    idle(0, 1);

    // Reset one cycle after a read grant: response dropped, pointer back to requester 0.
    cyc(0, 2'b10, 2'b10, 0, 0, 8'd7, 32'hCAFE_0007, 0, 2'b10, 0, 0, 0, 0);
    cyc(0, 2'b01, 2'b00, 8'd7, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    cyc(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc(0, 2'b11, 2'b00, 8'd7, 0, 8'd7, 0, 0, 2'b01, 0, 0, 1, 32'hCAFE_0007);
    idle(0, 0);

    // flush_req held three cycles: one pulse, then re-seen in ARB starts a second flush.
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0);
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0);
    idle(1, 0);
    idle(0, 1);

    // Contending writes: requester 1 holds priority and wins; requester 0 reads its value.
    cyc(0, 2'b11, 2'b11, 8'd9, 32'hDEAD_0009, 8'd9, 32'hBEEF_0009, 0, 2'b10, 0, 0, 0, 0);
    cyc(0, 2'b01, 2'b00, 8'd9, 0, 0, 0, 0, 2'b01, 0, 0, 1, 32'hBEEF_0009);
    idle(0, 0);
    idle(0, 0);

    @(negedge clk);
    #3;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, default `A_W-1, width of RAM word address.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports per requester i in {0,1}:
- req_i  in  1  access request.
- we_i  in  1  1=write, 0=read.
- addr_i  in  ADDR_W  word address.
- wdata_i  in  32  write data.
- gnt_i  out  1  request accepted this cycle.
- rvalid_i  out  1  read data valid.
- rdata_i  out  32  read data.
REQ-004 SHALL have control ports:
- flush_req  in  1  clear-RAM request pulse.
- flush_done  out  1  one-cycle flush-complete pulse.
REQ-005 SHALL have RAM-side ports:
- ram_ena  out  1  RAM enable.
- ram_wea  out  1  RAM write enable.
- ram_flush  out  1  RAM clear.
- ram_din  out  32  RAM write data.
- ram_addr  out  ADDR_W  RAM address.
- ram_dout  in  32  RAM read data.
- ram_read_valid  in  1  RAM read valid.

Function
REQ-006 SHALL implement FSM with states ARB and FLUSH; reset state ARB.
REQ-007 In ARB with flush_req=0, SHALL grant at most one requester per cycle; gnt_i combinational, gnt_i=1 only when req_i=1.
REQ-008 SHALL arbitrate round-robin: when both request, grant the requester not granted most recently; rr pointer updates only on a grant.
REQ-009 On grant, SHALL drive ram_ena=1, ram_wea=we_i, ram_addr=addr_i, ram_din=wdata_i of the winner in the same cycle; with no grant, ram_ena=0, ram_wea=0.
REQ-010 On a read grant, SHALL register a tag (valid bit plus owner index); one accepted read per cycle, back-to-back reads allowed.
REQ-011 SHALL drive rvalid_i = ram_read_valid AND tag valid AND tag owner==i, and rdata_i = ram_dout for both requesters; read latency exactly 1 cycle from gnt.
REQ-012 Write grant SHALL clear tag valid; a write completes on its grant cycle with no response.
REQ-013 flush_req=1 in ARB SHALL win over all requests: no grant that cycle; next state FLUSH.
REQ-014 In FLUSH, SHALL drive ram_flush=1 for exactly one cycle, grant nothing, clear tag valid, then return to ARB.
REQ-015 SHALL assert flush_done (registered) in the first ARB cycle after FLUSH; grants are allowed in that cycle.
REQ-016 SHALL ignore flush_req while in FLUSH; no re-trigger.
REQ-017 In-flight read at flush entry SHALL NOT produce rvalid: tag cleared on FLUSH entry.
REQ-018 ram_flush SHALL be 0 outside FLUSH.

Reset
REQ-019 rst SHALL force state=ARB, rr pointer favouring requester 0, tag valid=0, flush_done=0.
REQ-020 During rst, all gnt_i, rvalid_i, ram_ena, ram_wea, and ram_flush SHALL be 0; rdata_i follows ram_dout, which is 32'hFFFFFFFF after RAM reset.
REQ-021 rst asserted mid-read SHALL discard the pending response; no rvalid after release.

Structure
REQ-022 FSM state encoding and requester count (2) SHALL be constants in the shared param_define.v; ADDR_W derives from `A_W.
REQ-023 SHALL instantiate no sub-modules; the round-robin selector is a natural internal function.
REQ-024 Top-level integration SHALL connect ram_* to one single_port_ram instance with shared clk/rst.

Verification
REQ-025 Scenario: only req_0 write addr 5 data 0xA5A5A5A5, then req_0 read addr 5 -> gnt_0 each cycle; rvalid_0=1, rdata_0=0xA5A5A5A5 one cycle after read grant; rvalid_1=0.
REQ-026 Scenario: req_0 and req_1 both held high with reads for 4 cycles after reset -> grants 0,1,0,1; each rvalid routed to the correct requester one cycle later.
REQ-027 Scenario: write 0x1234 to addr 3; flush_req together with req_1 read -> no grant; ram_flush high next cycle; flush_done the cycle after; read addr 3 returns 0.
REQ-028 Scenario: read granted, flush_req next cycle -> rvalid suppressed for the in-flight read.
REQ-029 Scenario: rst asserted one cycle after read grant -> no rvalid; pointer favours requester 0 after release.
REQ-030 Scenario: flush_req held high for 3 cycles -> exactly one ram_flush pulse; then flush_req seen in ARB starts a second flush.
